// File: rtl/ans_decoder_stream_if.sv
// Stream bundle for the rANS decoder: word input stream and symbol output stream.
// The master modport is the environment (word producer / symbol consumer),
// the slave modport is the decoder.
interface ans_decoder_stream_if #(
  parameter int IO_WIDTH  = 4,
  parameter int SYM_WIDTH = 4
) ();
  logic [IO_WIDTH-1:0]  in_data;
  logic                 in_vld;
  logic                 in_rdy;
  logic [SYM_WIDTH-1:0] out_sym;
  logic                 out_vld;
  logic                 out_rdy;

  modport master (
    output in_data, in_vld, out_rdy,
    input  in_rdy, out_sym, out_vld
  );

  modport slave (
    input  in_data, in_vld, out_rdy,
    output in_rdy, out_sym, out_vld
  );
endinterface

// File: rtl/ans_decoder_stream.sv
// rANS stream decoder: loads the coder state word-serially, decodes num_syms
// symbols with a SYM_WIDTH-cycle binary search over the cumulative table and
// renormalises the state from the same input word stream.
module ans_decoder_stream #(
  parameter int SYM_WIDTH   = 4,
  parameter int SYM_COUNT   = 2 ** SYM_WIDTH,
  parameter int CNT_WIDTH   = 4,
  parameter int STATE_WIDTH = 16,
  parameter int IO_WIDTH    = 4,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     ena,
  input  logic [CNT_WIDTH*SYM_COUNT-1:0]           counts_unpacked,
  input  logic [(CNT_WIDTH+SYM_WIDTH)*SYM_COUNT-1:0] cumulative_unpacked,
  input  logic [LEN_WIDTH-1:0]                     num_syms,
  input  logic                                     start,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     err,
  ans_decoder_stream_if.slave                      bus
);

  localparam int CW        = CNT_WIDTH + SYM_WIDTH;   // cumulative entry width
  localparam int WORDS     = STATE_WIDTH / IO_WIDTH;  // words per state load
  localparam int WCW       = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int STEP_W    = (SYM_WIDTH > 1) ? $clog2(SYM_WIDTH) : 1;
  localparam int PW        = STATE_WIDTH + CNT_WIDTH;  // full product width
  localparam logic [STEP_W-1:0] STEP_INIT = STEP_W'(SYM_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_LOOKUP, S_EMIT, S_UPDATE, S_RENORM, S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [STATE_WIDTH-1:0] x_q, x_d;
  logic [LEN_WIDTH-1:0]   rem_q, rem_d;
  logic [WCW-1:0]         wcnt_q, wcnt_d;
  logic [SYM_WIDTH-1:0]   sym_q, sym_d;
  logic [STEP_W-1:0]      step_q, step_d;
  logic                   err_q, err_d;

  logic [CNT_WIDTH-1:0]   cnt [SYM_COUNT];
  logic [CW-1:0]          cum [SYM_COUNT];

  for (genvar i = 0; i < SYM_COUNT; i++) begin : g_unpack
    assign cnt[i] = counts_unpacked[i*CNT_WIDTH +: CNT_WIDTH];
    assign cum[i] = cumulative_unpacked[i*CW +: CW];
  end

  // Shared arithmetic on the current state; x is stable from LOOKUP to UPDATE,
  // so y and x div M are valid throughout the symbol.
  logic [CW-1:0]          m_total;
  logic [STATE_WIDTH-1:0] m_ext, m_div, quot;
  logic [CW-1:0]          y, cum_prev;
  logic [SYM_WIDTH-1:0]   probe, probe_idx;
  logic                   probe_le;
  logic [PW-1:0]          prod;
  logic                   prod_ovf;
  logic [STATE_WIDTH-1:0] x_upd, x_shift;
  logic                   shift_ovf;
  logic                   in_rdy_c, out_vld_c;

  assign m_total   = cum[SYM_COUNT-1];
  assign m_ext     = STATE_WIDTH'(m_total);
  // Divisor forced nonzero so the datapath is defined when M==0 (never used then).
  assign m_div     = (m_total == '0) ? STATE_WIDTH'(1) : m_ext;
  assign quot      = x_q / m_div;
  assign y         = CW'(x_q % m_div);

  // Binary search: one bit of the symbol per cycle, MSB first. Setting the bit
  // is kept when cum[probe-1] <= y, so the result counts entries with cum <= y,
  // i.e. the smallest s with cum[s] > y; zero-count symbols can never satisfy it.
  assign probe     = sym_q | (SYM_WIDTH'(1) << step_q);
  assign probe_idx = probe - SYM_WIDTH'(1);
  assign probe_le  = (cum[probe_idx] <= y);

  assign cum_prev  = (sym_q == '0) ? '0 : cum[sym_q - SYM_WIDTH'(1)];
  assign prod      = PW'(cnt[sym_q]) * PW'(quot);
  assign prod_ovf  = |prod[PW-1:STATE_WIDTH];
  assign x_upd     = prod[STATE_WIDTH-1:0] + STATE_WIDTH'(y) - STATE_WIDTH'(cum_prev);

  assign x_shift   = {x_q[STATE_WIDTH-IO_WIDTH-1:0], bus.in_data};
  assign shift_ovf = |x_q[STATE_WIDTH-1 -: IO_WIDTH];

  // Next-state, datapath and handshake decode for the frame FSM.
  // NOTE: every variable assigned below gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    rem_d     = rem_q;
    wcnt_d    = wcnt_q;
    sym_d     = sym_q;
    step_d    = step_q;
    err_d     = err_q;
    in_rdy_c  = 1'b0;
    out_vld_c = 1'b0;
    busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    done      = (state_q == S_DONE);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d  = (m_total == '0);
          rem_d  = num_syms;
          x_d    = '0;
          wcnt_d = '0;
          state_d = ((m_total == '0) || (num_syms == '0)) ? S_DONE : S_LOAD;
        end
      end

      S_LOAD: begin
        in_rdy_c = 1'b1;
        sym_d    = '0;
        step_d   = STEP_INIT;
        if (bus.in_vld) begin
          x_d = x_shift;
          if (wcnt_q == WCW'(WORDS - 1)) state_d = S_LOOKUP;
          else                           wcnt_d  = wcnt_q + WCW'(1);
        end
      end

      S_LOOKUP: begin
        if (probe_le) sym_d = probe;
        if (step_q == '0) state_d = S_EMIT;
        else              step_d  = step_q - STEP_W'(1);
      end

      S_EMIT: begin
        out_vld_c = 1'b1;
        if (bus.out_rdy) begin
          rem_d   = rem_q - LEN_WIDTH'(1);
          state_d = S_UPDATE;
        end
      end

      S_UPDATE: begin
        x_d    = x_upd;
        sym_d  = '0;
        step_d = STEP_INIT;
        if (prod_ovf) err_d = 1'b1;
        if (rem_q == '0)         state_d = S_DONE;
        else if (x_upd < m_ext)  state_d = S_RENORM;
        else                     state_d = S_LOOKUP;
      end

      S_RENORM: begin
        in_rdy_c = 1'b1;
        sym_d    = '0;
        step_d   = STEP_INIT;
        if (bus.in_vld) begin
          x_d = x_shift;
          if (shift_ovf) err_d = 1'b1;
          if (x_shift >= m_ext) state_d = S_LOOKUP;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_rdy  = in_rdy_c;
  assign bus.out_vld = out_vld_c;
  assign bus.out_sym = sym_q;
  assign err         = err_q;

  // State registers; everything holds while ena is low.
  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      rem_q   <= '0;
      wcnt_q  <= '0;
      sym_q   <= '0;
      step_q  <= '0;
      err_q   <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      x_q     <= x_d;
      rem_q   <= rem_d;
      wcnt_q  <= wcnt_d;
      sym_q   <= sym_d;
      step_q  <= step_d;
      err_q   <= err_d;
    end
  end

endmodule
